aes_engine_arbiter: RTL and testbench
=====================================

// Module: aes_engine_arbiter
// PURPOSE
//  Shares one AES engine (cipher/decipher with 128/192/256 key schedules) between two requesters.
//  Arbitrates round-robin, launches the engine, counts the fixed per-key-size latency, then returns
//  the result to the winning requester with a valid/ready response. Sits between host ports and the AES datapath.
// PARAMETERS
//  LAT_128  12  engine cycles from eng_start to valid eng_dout, 128-bit key
//  LAT_192  14  same, 192-bit key
//  LAT_256  16  same, 256-bit key
//  CNT_W    5   latency counter width; must hold LAT_256-1
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    asynchronous, active-low reset
//  reqN_valid   in   1    N=0,1: request present
//  reqN_ready   out  1    N=0,1: request accepted this cycle (valid&&ready)
//  reqN_data    in   128  N=0,1: plaintext (enc) or ciphertext (dec)
//  reqN_keysel  in   2    N=0,1: 00=128, 01=192, 10=256, 11=illegal
//  reqN_dec     in   1    N=0,1: 1=decipher, 0=cipher
//  rspN_valid   out  1    N=0,1: response held until rspN_ready
//  rspN_ready   in   1    N=0,1: response consumed
//  rspN_data    out  128  N=0,1: result; 0 when rspN_err
//  rspN_err     out  1    N=0,1: request had illegal keysel
//  eng_start    out  1    one-cycle launch pulse to engine
//  eng_din      out  128  engine input block
//  eng_keysel   out  2    engine key-size select
//  eng_dec      out  1    engine direction
//  eng_dout     in   128  engine result
//  busy         out  1    high in any state other than IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, last_grant=1, all outputs 0, in-flight request discarded; requester reissues.
//  FSM IDLE->LOAD->RUN->RESP->IDLE; IDLE->RESP directly for illegal keysel.
//  IDLE: reqN_ready combinational = (state==IDLE) && grant==N; at most one ready high per cycle.
//   Grant: only one valid -> it; both valid -> requester != last_grant. On accept latch data/keysel/dec,
//   set last_grant=N. Legal keysel -> LOAD; keysel 11 -> RESP with rsp_err=1, data=0.
//  LOAD (1 cycle): eng_start=1; counter loaded with LAT_x-1 by latched keysel.
//  RUN: counter decrements each cycle; at 0 capture eng_dout into rsp register -> RESP.
//   eng_din/eng_keysel/eng_dec stable from LOAD through last RUN cycle; eng_start low outside LOAD.
//  Latency accept->rspN_valid: LAT_x+2 cycles (128: 14, 192: 16, 256: 18); illegal: 1 cycle.
//  RESP: rspN_valid=1 for granted N only, data/err stable; on rspN_ready -> IDLE, valid drops next cycle.
//   Next accept earliest the cycle after return to IDLE (one bubble; no same-cycle release+accept).
//  Requests arriving while busy wait (ready=0); valid may drop before acceptance without effect.
//  rspN_ready while rspN_valid=0 ignored. keysel/dec changes after accept ignored.
// CONFIGURATION
//  AES_ARB_FIXED_PRIO_EN defined: fixed priority, req0 always wins when both valid; last_grant unused.
//  Not defined: round-robin as above (default).
// TESTING
//  1 req0 enc keysel=00 data=00112233445566778899aabbccddeeff -> rsp0_data=69c4e0d86a7b0430d8cdb78070b4c55a, valid 14 cycles after accept.
//  2 req1 dec keysel=10 data=8ea2b7ca516745bfeafc49904b496089 -> rsp1_data=00112233445566778899aabbccddeeff at accept+18.
//  3 req0,req1 valid together from reset x4 jobs -> grants 0,1,0,1; with AES_ARB_FIXED_PRIO_EN -> 0,0,0,0 while req0 held.
//  4 req0 keysel=11 -> rsp0_valid at accept+1, rsp0_err=1, rsp0_data=0, eng_start never asserted.
//  5 reset=0 mid-RUN (keysel 01) -> all outputs 0 at once; after release re-request gives dda97ca4864cdfe06eaf70a0ec0d7191.
//  6 hold rsp0_ready=0 for 10 cycles in RESP -> rsp0_valid/data stable, req1_ready stays 0, busy=1.

Source files
------------

// File: rtl/aes_engine_arbiter_if.sv
// Host request/response ports and AES engine ports of the shared-engine arbiter.
// The arbiter uses the slave modport; the hosts plus the engine side use master.
interface aes_engine_arbiter_if;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned KS_W   = 2;

  // requester 0
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [KS_W-1:0]   req0_keysel;
  logic              req0_dec;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_err;

  // requester 1
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [KS_W-1:0]   req1_keysel;
  logic              req1_dec;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_err;

  // engine side
  logic              eng_start;
  logic [DATA_W-1:0] eng_din;
  logic [KS_W-1:0]   eng_keysel;
  logic              eng_dec;
  logic [DATA_W-1:0] eng_dout;

  logic              busy;

  modport slave (
    input  req0_valid, req0_data, req0_keysel, req0_dec, rsp0_ready,
    input  req1_valid, req1_data, req1_keysel, req1_dec, rsp1_ready,
    input  eng_dout,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    output eng_start, eng_din, eng_keysel, eng_dec,
    output busy
  );

  modport master (
    output req0_valid, req0_data, req0_keysel, req0_dec, rsp0_ready,
    output req1_valid, req1_data, req1_keysel, req1_dec, rsp1_ready,
    output eng_dout,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    input  eng_start, eng_din, eng_keysel, eng_dec,
    input  busy
  );
endinterface

// File: rtl/aes_engine_arbiter.sv
// Two-requester arbiter in front of one fixed-latency AES engine.
// Grants one request at a time, launches the engine, waits the key-size
// dependent latency and returns the result on the winner's response port.
// Build option: AES_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins
// contention); left undefined the arbiter alternates round-robin.
module aes_engine_arbiter #(
  parameter int unsigned LAT_128 = 12,
  parameter int unsigned LAT_192 = 14,
  parameter int unsigned LAT_256 = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_engine_arbiter_if.slave  bus
);

  localparam int unsigned DATA_W = 128;
  localparam int unsigned KS_W   = 2;
  localparam logic [KS_W-1:0] KS_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;        // current (or most recent) grant
  logic [DATA_W-1:0] data_q, data_d;
  logic [KS_W-1:0]   keysel_q, keysel_d;
  logic              dec_q, dec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              eng_start_q, eng_start_d;
  logic              busy_q, busy_d;

  logic              grant_c;
  logic              accept_c;
  logic              release_c;
  logic [DATA_W-1:0] sel_data_c;
  logic [KS_W-1:0]   sel_keysel_c;
  logic              sel_dec_c;

  // Engine latency minus one, the counter preload for each key size.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [KS_W-1:0] ks);
    case (ks)
      2'b00:   return CNT_W'(LAT_128 - 1);
      2'b01:   return CNT_W'(LAT_192 - 1);
      2'b10:   return CNT_W'(LAT_256 - 1);
      default: return '0;
    endcase
  endfunction

  // Pick the winner among the currently valid requesters.
  always_comb begin
    grant_c = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef AES_ARB_FIXED_PRIO_EN
      grant_c = 1'b0;
`else
      grant_c = ~owner_q;
`endif
    end else if (bus.req1_valid) begin
      grant_c = 1'b1;
    end
  end

  // Accept only from IDLE; ready is suppressed while reset is asserted.
  assign accept_c  = reset && (state_q == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
  assign release_c = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.req0_ready = accept_c && !grant_c;
  assign bus.req1_ready = accept_c &&  grant_c;

  // Request payload of the winning requester.
  always_comb begin
    sel_data_c   = grant_c ? bus.req1_data   : bus.req0_data;
    sel_keysel_c = grant_c ? bus.req1_keysel : bus.req0_keysel;
    sel_dec_c    = grant_c ? bus.req1_dec    : bus.req0_dec;
  end

  // Next-state and register updates for the IDLE/LOAD/RUN/RESP sequence.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    data_d      = data_q;
    keysel_d    = keysel_q;
    dec_d       = dec_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    eng_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          owner_d  = grant_c;
          data_d   = sel_data_c;
          keysel_d = sel_keysel_c;
          dec_d    = sel_dec_c;
          if (sel_keysel_c == KS_ILLEGAL) begin
            state_d     = ST_RESP;
            rsp_valid_d = grant_c ? 2'b10 : 2'b01;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ST_LOAD;
            eng_start_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        cnt_d   = lat_m1(keysel_q);
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_data_d  = bus.eng_dout;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (release_c) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 2'b00;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset discards any in-flight job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b1;
      data_q      <= '0;
      keysel_q    <= '0;
      dec_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      data_q      <= data_d;
      keysel_q    <= keysel_d;
      dec_q       <= dec_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      eng_start_q <= eng_start_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp0_data  = rsp_data_q;
  assign bus.rsp1_data  = rsp_data_q;
  assign bus.rsp0_err   = rsp_err_q;
  assign bus.rsp1_err   = rsp_err_q;
  assign bus.eng_start  = eng_start_q;
  assign bus.eng_din    = data_q;
  assign bus.eng_keysel = keysel_q;
  assign bus.eng_dec    = dec_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_aes_engine_arbiter.sv
// Bench for aes_engine_arbiter: directed scenarios plus random jobs checked
// against a request-level model of arbitration, latency and results.
module tb_aes_engine_arbiter;
  localparam int LAT_128 = 12;
  localparam int LAT_192 = 14;
  localparam int LAT_256 = 16;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  aes_engine_arbiter_if bus ();

  aes_engine_arbiter #(
    .LAT_128(LAT_128), .LAT_192(LAT_192), .LAT_256(LAT_256), .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int total = 0;
  int bad = 0;
  int starts = 0;
  int s0 = 0;
  bit last_g = 1'b1;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int lat_of(logic [1:0] ks);
    case (ks)
      2'b00:   return LAT_128;
      2'b01:   return LAT_192;
      2'b10:   return LAT_256;
      default: return 0;
    endcase
  endfunction

  // Stand-in AES: known vectors, otherwise a keyed scramble.
  function automatic logic [127:0] ref_eng(logic [127:0] d, logic [1:0] ks, logic dec);
    if (d == PT && ks == 2'b00 && !dec) return CT128;
    if (d == PT && ks == 2'b01 && !dec) return CT192;
    if (d == CT256 && ks == 2'b10 && dec) return PT;
    return {d[63:0], d[127:64]} ^ {ks, dec, 125'h1a5};
  endfunction

  // Arbitration rule seen from the request side.
  function automatic bit model_grant(bit v0, bit v1, bit last);
    if (v0 && v1) begin
`ifdef AES_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return !last;
`endif
    end
    return v1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine model: result valid exactly LAT cycles after the start pulse.
  int e_cnt = 0;
  logic [127:0] e_res;
  logic [130:0] e_cmd;
  always @(negedge clk) begin
    if (!reset) begin
      e_cnt = 0;
      bus.eng_dout = rand128();
    end else if (bus.eng_start) begin
      starts++;
      e_cnt = lat_of(bus.eng_keysel);
      e_res = ref_eng(bus.eng_din, bus.eng_keysel, bus.eng_dec);
      e_cmd = {bus.eng_din, bus.eng_keysel, bus.eng_dec};
      bus.eng_dout = rand128();
    end else if (e_cnt > 0) begin
      e_cnt--;
      if (e_cnt == 0) begin
        bus.eng_dout = e_res;
        chk("eng_cmd_stable", 128'({bus.eng_din, bus.eng_keysel, bus.eng_dec} ^ e_cmd), 128'd0);
      end else begin
        bus.eng_dout = rand128();
      end
    end else begin
      bus.eng_dout = rand128();
    end
  end

  task automatic set_req(input bit n, input bit v, input logic [127:0] d,
                         input logic [1:0] ks, input bit dec);
    if (n) begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_keysel = ks; bus.req1_dec = dec;
    end else begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_keysel = ks; bus.req0_dec = dec;
    end
  endtask

  // Wait for a ready, check it belongs to the expected winner, take the accept edge.
  task automatic accept_one(input bit exp_g);
    int n;
    n = 0;
    #1;
    while (!(bus.req0_ready || bus.req1_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("grant", 128'({bus.req1_ready, bus.req0_ready}), exp_g ? 128'd2 : 128'd1);
    s0 = starts;
    @(posedge clk);
    #1;
  endtask

  // Check response latency/content, optionally stall, then consume it.
  task automatic wait_rsp(input bit g, input int exp_lat, input logic [127:0] exp_d,
                          input bit exp_err, input int hold);
    int n;
    bit seen;
    logic [127:0] d0;
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_after_accept", 128'(bus.busy), 128'd1);
      seen = g ? bus.rsp1_valid : bus.rsp0_valid;
    end
    chk("rsp_latency", 128'(n), 128'(exp_lat));
    chk("rsp_data", g ? bus.rsp1_data : bus.rsp0_data, exp_d);
    chk("rsp_err", 128'(g ? bus.rsp1_err : bus.rsp0_err), 128'(exp_err));
    chk("rsp_other_idle", 128'(g ? bus.rsp0_valid : bus.rsp1_valid), 128'd0);
    chk("eng_starts", 128'(starts - s0), exp_err ? 128'd0 : 128'd1);
    d0 = g ? bus.rsp1_data : bus.rsp0_data;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 128'(g ? bus.rsp1_valid : bus.rsp0_valid), 128'd1);
      chk("hold_data", g ? bus.rsp1_data : bus.rsp0_data, d0);
      chk("hold_busy", 128'(bus.busy), 128'd1);
      chk("hold_no_ready", 128'(bus.req0_ready | bus.req1_ready), 128'd0);
    end
    if (g) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_drop", 128'(g ? bus.rsp1_valid : bus.rsp0_valid), 128'd0);
    chk("busy_idle", 128'(bus.busy), 128'd0);
  endtask

  initial begin
    bit g;
    bit v0, v1;
    logic [127:0] d0r, d1r, dg;
    logic [1:0] k0, k1, kg;
    bit e0, e1, eg;
    int vv;

    set_req(0, 0, '0, 2'b00, 0);
    set_req(1, 0, '0, 2'b00, 0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    bus.eng_dout = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_rsp_valid", 128'({bus.rsp1_valid, bus.rsp0_valid}), 128'd0);
    chk("rst_eng_start", 128'(bus.eng_start), 128'd0);
    chk("rst_eng_din", bus.eng_din, 128'd0);
    reset = 1'b1;
    last_g = 1'b1;

    // Both requesters held valid from reset: four jobs
    d0r = rand128();
    d1r = rand128();
    set_req(0, 1, d0r, 2'b00, 0);
    set_req(1, 1, d1r, 2'b00, 0);
    for (int k = 0; k < 4; k++) begin
      g = model_grant(1'b1, 1'b1, last_g);
      accept_one(g);
      if (k == 3) begin
        set_req(0, 0, d0r, 2'b00, 0);
        set_req(1, 0, d1r, 2'b00, 0);
      end
      wait_rsp(g, LAT_128 + 2, ref_eng(g ? d1r : d0r, 2'b00, 1'b0), 1'b0, 0);
      last_g = g;
    end

    // Known-answer: 128-bit encrypt on req0
    set_req(0, 1, PT, 2'b00, 0);
    accept_one(0);
    set_req(0, 0, rand128(), 2'b10, 1);
    wait_rsp(0, LAT_128 + 2, CT128, 1'b0, 0);
    last_g = 1'b0;

    // Known-answer: 256-bit decrypt on req1
    set_req(1, 1, CT256, 2'b10, 1);
    accept_one(1);
    set_req(1, 0, rand128(), 2'b00, 0);
    wait_rsp(1, LAT_256 + 2, PT, 1'b0, 0);
    last_g = 1'b1;

    // Illegal key select
    set_req(0, 1, rand128(), 2'b11, 0);
    accept_one(0);
    set_req(0, 0, '0, 2'b00, 0);
    wait_rsp(0, 1, 128'd0, 1'b1, 0);
    last_g = 1'b0;

    // Response stalled 10 cycles while req1 waits, then req1 is served
    d0r = rand128();
    set_req(0, 1, d0r, 2'b00, 0);
    accept_one(0);
    set_req(0, 0, '0, 2'b00, 0);
    set_req(1, 1, PT, 2'b01, 0);
    wait_rsp(0, LAT_128 + 2, ref_eng(d0r, 2'b00, 1'b0), 1'b0, 10);
    last_g = 1'b0;
    accept_one(1);
    set_req(1, 0, '0, 2'b00, 0);
    wait_rsp(1, LAT_192 + 2, CT192, 1'b0, 0);
    last_g = 1'b1;

    // Random jobs
    for (int j = 0; j < 12; j++) begin
      vv = $urandom_range(1, 3);
      v0 = vv[0];
      v1 = vv[1];
      d0r = rand128();
      d1r = rand128();
      k0 = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      k1 = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      e0 = 1'($urandom_range(0, 1));
      e1 = 1'($urandom_range(0, 1));
      set_req(0, v0, d0r, k0, e0);
      set_req(1, v1, d1r, k1, e1);
      g  = model_grant(v0, v1, last_g);
      dg = g ? d1r : d0r;
      kg = g ? k1 : k0;
      eg = g ? e1 : e0;
      accept_one(g);
      set_req(0, 0, rand128(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      set_req(1, 0, rand128(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if (kg == 2'b11)
        wait_rsp(g, 1, 128'd0, 1'b1, $urandom_range(0, 3));
      else
        wait_rsp(g, lat_of(kg) + 2, ref_eng(dg, kg, eg), 1'b0, $urandom_range(0, 3));
      last_g = g;
    end

    // Reset in the middle of a 192-bit job, then reissue
    set_req(0, 1, PT, 2'b01, 0);
    accept_one(0);
    repeat (6) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_busy", 128'(bus.busy), 128'd0);
    chk("midrst_eng_start", 128'(bus.eng_start), 128'd0);
    chk("midrst_eng_din", bus.eng_din, 128'd0);
    chk("midrst_eng_ctl", 128'({bus.eng_keysel, bus.eng_dec}), 128'd0);
    chk("midrst_rsp0", 128'({bus.rsp0_valid, bus.rsp0_err}), 128'd0);
    chk("midrst_rsp0_data", bus.rsp0_data, 128'd0);
    chk("midrst_ready", 128'({bus.req1_ready, bus.req0_ready}), 128'd0);
    @(negedge clk);
    reset = 1'b1;
    last_g = 1'b1;
    accept_one(0);
    set_req(0, 0, '0, 2'b00, 0);
    wait_rsp(0, LAT_192 + 2, CT192, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
